// File: rtl/traffic_phase_sequencer.sv
// Two-street intersection phase sequencer. It applies min/max green, a fixed yellow and a
// one-cycle all-red, and serves a latched pedestrian request with an all-red WALK phase.
module traffic_phase_sequencer #(
    parameter int unsigned MIN_GREEN   = 4,
    parameter int unsigned MAX_GREEN   = 10,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned WALK_TIME   = 3,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       T,
    input  logic             ped_req,
    output logic [3:0]       S,
    output logic [3:0]       next_S,
    output logic [1:0]       La,
    output logic [1:0]       Lb,
    output logic             walk,
    output logic [CNT_W-1:0] timer
);

    typedef enum logic [3:0] {
        ST_AG   = 4'd0,
        ST_AY   = 4'd1,
        ST_AR   = 4'd2,
        ST_BG   = 4'd3,
        ST_BY   = 4'd4,
        ST_BR   = 4'd5,
        ST_WALK = 4'd6
    } state_e;

    localparam logic [1:0] L_GRN = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_RED = 2'b10;

    localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_TIME - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_q, ped_d;
    logic             last_b_q, last_b_d;   // 1: WALK was entered after the B green
    logic             ta, tb, want_a, want_b;

    assign ta     = T[1];
    assign tb     = T[0];
    assign want_a = ta | ped_q;
    assign want_b = tb | ped_q;

    // Next-state, timer, pedestrian latch and direction memory
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ped_d    = ped_q;
        last_b_d = last_b_q;
        case (state_q)
            ST_AG: if (timer_q >= MIN_M1 && want_b && (!ta || timer_q >= MAX_M1)) state_d = ST_AY;
            ST_AY: if (timer_q == YEL_M1) state_d = ST_AR;
            ST_AR: state_d = ped_q ? ST_WALK : ST_BG;
            ST_BG: if (timer_q >= MIN_M1 && want_a && (!tb || timer_q >= MAX_M1)) state_d = ST_BY;
            ST_BY: if (timer_q == YEL_M1) state_d = ST_BR;
            ST_BR: state_d = ped_q ? ST_WALK : ST_AG;
            ST_WALK: if (timer_q == WALK_M1) state_d = last_b_q ? ST_AG : ST_BG;
            default: state_d = ST_AG;
        endcase
        if (rst) state_d = ST_AG;

        if (state_d != state_q)   timer_d = '0;
        else if (timer_q != '1)   timer_d = timer_q + 1'b1;

        // Entering WALK clears the request even if the button is pressed on that edge
        if (state_d == ST_WALK && state_q != ST_WALK)  ped_d = 1'b0;
        else if (ped_req && state_q != ST_WALK)        ped_d = 1'b1;

        if (state_q == ST_AR)      last_b_d = 1'b0;
        else if (state_q == ST_BR) last_b_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_AG;
            timer_q  <= '0;
            ped_q    <= 1'b0;
            last_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ped_q    <= ped_d;
            last_b_q <= last_b_d;
        end
    end

    // Moore light decode from the state register
    always_comb begin
        La   = L_RED;
        Lb   = L_RED;
        walk = 1'b0;
        case (state_q)
            ST_AG:   La = L_GRN;
            ST_AY:   La = L_YEL;
            ST_BG:   Lb = L_GRN;
            ST_BY:   Lb = L_YEL;
            ST_WALK: walk = 1'b1;
            default: ;
        endcase
    end

    assign S      = state_q;
    assign next_S = state_d;
    assign timer  = timer_q;

endmodule
